// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS9 link-test receive path: LFSR taps, FSM encoding
// and default lock/loss tuning.
package prbs_pkg;

   localparam int unsigned TAP_A = 8;
   localparam int unsigned TAP_B = 4;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SYNC   = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam int unsigned SYNC_LEN_DEF = 16;
   localparam int unsigned LOSS_WIN_DEF = 64;
   localparam int unsigned LOSS_THR_DEF = 8;

   // History depth of PRBS9; prediction is only meaningful once this many bits are in.
   localparam logic [3:0] FILL_FULL = 4'd9;

endpackage

// File: rtl/prbs9_lfsr_core.sv
// PRBS9 history register: shifts in either the received bit (sync) or its own
// prediction (free-running reference once locked).
module prbs9_lfsr_core
   import prbs_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_load_pred,
   input  logic i_rx_bit,
   output logic o_pred
);

   logic [8:0] r_hist;
   logic       w_load_bit;

   assign o_pred     = r_hist[TAP_A] ^ r_hist[TAP_B];
   assign w_load_bit = i_load_pred ? o_pred : i_rx_bit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hist <= '0;
      end else if (i_en) begin
         r_hist <= {r_hist[7:0], w_load_bit};
      end
   end

endmodule

// File: rtl/prbs9_ber_ctrl.sv
// PRBS9 receive controller: self-synchronises a reference to rx, then counts
// compared bits and errors over a window, re-syncing on loss of lock.
module prbs9_ber_ctrl
   import prbs_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned SYNC_LEN = SYNC_LEN_DEF,
   parameter int unsigned LOSS_WIN = LOSS_WIN_DEF,
   parameter int unsigned LOSS_THR = LOSS_THR_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_win_len,
   input  logic             i_rx_valid,
   input  logic             i_rx_bit,
   output logic             o_busy,
   output logic             o_locked,
   output logic             o_done,
   output logic [CNT_W-1:0] o_bit_count,
   output logic [CNT_W-1:0] o_err_count,
   output logic [7:0]       o_loss_count
);

   localparam int unsigned MW = $clog2(SYNC_LEN + 1);
   localparam int unsigned BW = $clog2(LOSS_WIN + 1);
   localparam int unsigned EW = $clog2(LOSS_THR + 1);
   localparam logic [MW-1:0] SYNC_V   = MW'(SYNC_LEN);
   localparam logic [BW-1:0] BLK_LAST = BW'(LOSS_WIN - 1);
   localparam logic [EW-1:0] THR_V    = EW'(LOSS_THR);

   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_win_len;
   logic [CNT_W-1:0] r_bit_count, w_bit_nxt, w_bit_inc;
   logic [CNT_W-1:0] r_err_count, w_err_nxt, w_err_inc;
   logic [7:0]       r_loss_count, w_loss_nxt, w_loss_inc;
   logic [3:0]       r_fill, w_fill_nxt;
   logic [MW-1:0]    r_match, w_match_nxt, w_match_inc;
   logic [BW-1:0]    r_blk_cnt, w_blk_cnt_nxt;
   logic [EW-1:0]    r_blk_err, w_blk_err_nxt, w_blk_err_inc;
   logic             w_pred, w_mis, w_hist_en, w_load_pred;

   prbs9_lfsr_core u_lfsr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (w_hist_en),
      .i_load_pred (w_load_pred),
      .i_rx_bit    (i_rx_bit),
      .o_pred      (w_pred)
   );

   assign w_mis         = i_rx_bit ^ w_pred;
   assign w_bit_inc     = (&r_bit_count)  ? r_bit_count  : r_bit_count + CNT_W'(1);
   assign w_err_inc     = (&r_err_count)  ? r_err_count  : r_err_count + CNT_W'(1);
   assign w_loss_inc    = (&r_loss_count) ? r_loss_count : r_loss_count + 8'd1;
   assign w_match_inc   = r_match + MW'(1);
   assign w_blk_err_inc = r_blk_err + EW'(w_mis);

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_nxt     = r_bit_count;
      w_err_nxt     = r_err_count;
      w_loss_nxt    = r_loss_count;
      w_fill_nxt    = r_fill;
      w_match_nxt   = r_match;
      w_blk_cnt_nxt = r_blk_cnt;
      w_blk_err_nxt = r_blk_err;
      w_hist_en     = 1'b0;
      w_load_pred   = 1'b0;
      if (i_start) begin
         w_state_nxt = SYNC;
         w_bit_nxt   = '0;
         w_err_nxt   = '0;
         w_loss_nxt  = '0;
         w_fill_nxt  = '0;
         w_match_nxt = '0;
      end else if (i_rx_valid) begin
         case (r_state)
            SYNC: begin
               w_hist_en = 1'b1;
               if (r_fill != FILL_FULL) begin
                  w_fill_nxt = r_fill + 4'd1;
               end else if (!w_mis) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == SYNC_V) begin
                     w_state_nxt   = LOCKED;
                     w_blk_cnt_nxt = '0;
                     w_blk_err_nxt = '0;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end
            LOCKED: begin
               w_hist_en   = 1'b1;
               w_load_pred = 1'b1;
               w_bit_nxt   = w_bit_inc;
               if (w_mis) w_err_nxt = w_err_inc;
               if (r_blk_cnt == BLK_LAST) begin
                  w_blk_cnt_nxt = '0;
                  w_blk_err_nxt = '0;
               end else begin
                  w_blk_cnt_nxt = r_blk_cnt + BW'(1);
                  w_blk_err_nxt = w_blk_err_inc;
               end
               // Window completion wins over a loss detected on the same bit.
               if ((r_win_len != '0) && (w_bit_inc == r_win_len)) begin
                  w_state_nxt = DONE;
               end else if (w_blk_err_inc == THR_V) begin
                  w_state_nxt = SYNC;
                  w_loss_nxt  = w_loss_inc;
                  w_fill_nxt  = '0;
                  w_match_nxt = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_win_len    <= '0;
         r_bit_count  <= '0;
         r_err_count  <= '0;
         r_loss_count <= '0;
         r_fill       <= '0;
         r_match      <= '0;
         r_blk_cnt    <= '0;
         r_blk_err    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_count  <= w_bit_nxt;
         r_err_count  <= w_err_nxt;
         r_loss_count <= w_loss_nxt;
         r_fill       <= w_fill_nxt;
         r_match      <= w_match_nxt;
         r_blk_cnt    <= w_blk_cnt_nxt;
         r_blk_err    <= w_blk_err_nxt;
         if (i_start) r_win_len <= i_win_len;
      end
   end

   assign o_busy       = (r_state == SYNC) || (r_state == LOCKED);
   assign o_locked     = (r_state == LOCKED);
   assign o_done       = (r_state == DONE);
   assign o_bit_count  = r_bit_count;
   assign o_err_count  = r_err_count;
   assign o_loss_count = r_loss_count;

endmodule

// File: tb/tb_prbs9_ber_ctrl.sv
// Scenario bench for prbs9_ber_ctrl: expectations are queued as stimulus is
// planned and compared against observations once the DUT has responded.
module tb_prbs9_ber_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, rx_valid, rx_bit;
   logic [31:0] win_len;
   logic [3:0]  win_len4;
   logic        busy, locked, done;
   logic [31:0] bit_count, err_count;
   logic [7:0]  loss_count;
   logic        s_busy, s_locked, s_done;
   logic [3:0]  s_bit_count, s_err_count;
   logic [7:0]  s_loss_count;

   prbs9_ber_ctrl #(.CNT_W(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_win_len(win_len),
      .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
      .o_busy(busy), .o_locked(locked), .o_done(done),
      .o_bit_count(bit_count), .o_err_count(err_count), .o_loss_count(loss_count)
   );

   prbs9_ber_ctrl #(.CNT_W(4)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_win_len(win_len4),
      .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
      .o_busy(s_busy), .o_locked(s_locked), .o_done(s_done),
      .o_bit_count(s_bit_count), .o_err_count(s_err_count), .o_loss_count(s_loss_count)
   );

   always #5 clk = ~clk;

   logic [8:0]  g;
   int          n_total, n_bad;
   int          vbits, cycles, lock_bit, lock_cyc;
   logic        dropped;
   string       name_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   function automatic void expect_v(input string n, input logic [31:0] v);
      name_q.push_back(n);
      exp_q.push_back(v);
   endfunction

   function automatic void observe(input logic [31:0] v);
      obs_q.push_back(v);
   endfunction

   task automatic gen_bit(output logic b);
      b = g[8] ^ g[4];
      g = {g[7:0], b};
   endtask

   task automatic send(input logic v, input logic b);
      rx_valid = v;
      rx_bit   = b;
      @(posedge clk);
      #1;
      cycles++;
      if (v) vbits++;
      if (locked && lock_bit < 0) begin
         lock_bit = vbits;
         lock_cyc = cycles;
      end
      if (lock_bit >= 0 && !locked && !done) dropped = 1'b1;
   endtask

   task automatic pulse_start(input logic [31:0] wl);
      win_len  = wl;
      rx_valid = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      vbits    = 0;
      cycles   = 0;
      lock_bit = -1;
      lock_cyc = -1;
      dropped  = 1'b0;
   endtask

   task automatic run_to_lock(input int budget);
      logic b;
      for (int i = 0; i < budget && !locked; i++) begin
         gen_bit(b);
         send(1'b1, b);
      end
   endtask

   task automatic test_reset;
      string nm;
      logic [31:0] ev, ov;
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; win_len = '0;
      expect_v("rst_busy", 0);   expect_v("rst_locked", 0); expect_v("rst_done", 0);
      expect_v("rst_bits", 0);   expect_v("rst_errs", 0);   expect_v("rst_loss", 0);
      repeat (3) @(posedge clk);
      #1;
      observe(32'(busy)); observe(32'(locked)); observe(32'(done));
      observe(bit_count); observe(err_count); observe(32'(loss_count));
      rst = 1'b0;
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_clean_window;
      string nm;
      logic [31:0] ev, ov;
      logic b;
      g = 9'h0A1;
      expect_v("t1_busy_after_start", 1); expect_v("t1_locked_after_start", 0);
      expect_v("t1_lock_bit", 25);        expect_v("t1_total_valid", 1025);
      expect_v("t1_bits", 1000);          expect_v("t1_errs", 0);
      expect_v("t1_loss", 0);             expect_v("t1_done", 1);
      expect_v("t1_busy_end", 0);         expect_v("t1_bits_frozen", 1000);
      pulse_start(32'd1000);
      observe(32'(busy)); observe(32'(locked));
      for (int i = 0; i < 3000 && !done; i++) begin
         gen_bit(b);
         send(1'b1, b);
      end
      observe(32'(lock_bit)); observe(32'(vbits)); observe(bit_count);
      observe(err_count); observe(32'(loss_count)); observe(32'(done)); observe(32'(busy));
      for (int i = 0; i < 20; i++) begin
         gen_bit(b);
         send(1'b1, ~b);
      end
      observe(bit_count);
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_single_error;
      string nm;
      logic [31:0] ev, ov;
      logic b;
      g = 9'h0A1;
      expect_v("t2_errs", 1);   expect_v("t2_bits", 1000);
      expect_v("t2_dropped", 0); expect_v("t2_done", 1);
      pulse_start(32'd1000);
      for (int i = 0; i < 3000 && !done; i++) begin
         gen_bit(b);
         if (lock_bit >= 0 && vbits + 1 == lock_bit + 200) b = ~b;
         send(1'b1, b);
      end
      observe(err_count); observe(bit_count); observe(32'(dropped)); observe(32'(done));
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_inverted;
      string nm;
      logic [31:0] ev, ov;
      logic b;
      g = 9'h0A1;
      expect_v("t3_no_lock", 32'hFFFF_FFFF); expect_v("t3_busy", 1);
      expect_v("t3_bits", 0);                expect_v("t3_errs", 0);
      pulse_start(32'd0);
      for (int i = 0; i < 500; i++) begin
         gen_bit(b);
         send(1'b1, ~b);
      end
      observe(32'(lock_bit)); observe(32'(busy)); observe(bit_count); observe(err_count);
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_loss_of_lock;
      string nm;
      logic [31:0] ev, ov;
      logic b, locked_at7;
      int relock;
      g = 9'h0A1;
      expect_v("t4_lock_bit", 25);     expect_v("t4_locked_after_7", 1);
      expect_v("t4_locked_after_8", 0); expect_v("t4_loss", 1);
      expect_v("t4_errs", 8);           expect_v("t4_relock_bits", 25);
      expect_v("t4_bits", 38);
      pulse_start(32'd0);
      run_to_lock(100);
      observe(32'(lock_bit));
      for (int i = 0; i < 30; i++) begin
         gen_bit(b);
         send(1'b1, b);
      end
      locked_at7 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         gen_bit(b);
         send(1'b1, ~b);
         if (k == 6) locked_at7 = locked;
      end
      observe(32'(locked_at7)); observe(32'(locked)); observe(32'(loss_count));
      observe(err_count);
      relock = 0;
      while (!locked && relock < 100) begin
         gen_bit(b);
         send(1'b1, b);
         relock++;
      end
      observe(32'(relock)); observe(bit_count);
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_sparse_valid;
      string nm;
      logic [31:0] ev, ov;
      logic b, v;
      g = 9'h0A1;
      expect_v("t5_lock_bit", 25); expect_v("t5_lock_cycle", 73);
      expect_v("t5_bits", 1000);   expect_v("t5_errs", 0);
      expect_v("t5_loss", 0);      expect_v("t5_done", 1);
      pulse_start(32'd1000);
      for (int i = 0; i < 4000 && !done; i++) begin
         v = (cycles % 3 == 0);
         if (v) gen_bit(b);
         else b = 1'($urandom);
         send(v, b);
      end
      observe(32'(lock_bit)); observe(32'(lock_cyc)); observe(bit_count);
      observe(err_count); observe(32'(loss_count)); observe(32'(done));
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_restart_and_reset;
      string nm;
      logic [31:0] ev, ov;
      logic b;
      g = 9'h0A1;
      expect_v("t6_errs_before", 5);  expect_v("t6_locked_before", 1);
      expect_v("t6_bits_after", 0);   expect_v("t6_errs_after", 0);
      expect_v("t6_loss_after", 0);   expect_v("t6_busy_after", 1);
      expect_v("t6_locked_after", 0); expect_v("t6_relock_bit", 25);
      expect_v("t6_rst_busy", 0);     expect_v("t6_rst_locked", 0);
      expect_v("t6_rst_bits", 0);     expect_v("t6_rst_errs", 0);
      expect_v("t6_rst_over_start", 0);
      pulse_start(32'd0);
      run_to_lock(100);
      for (int i = 0; i < 25; i++) begin
         gen_bit(b);
         send(1'b1, (i >= 10 && i < 15) ? ~b : b);
      end
      observe(err_count); observe(32'(locked));
      pulse_start(32'd0);
      observe(bit_count); observe(err_count); observe(32'(loss_count));
      observe(32'(busy)); observe(32'(locked));
      run_to_lock(100);
      observe(32'(lock_bit));
      for (int i = 0; i < 10; i++) begin
         gen_bit(b);
         send(1'b1, ~b);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      observe(32'(busy)); observe(32'(locked)); observe(bit_count); observe(err_count);
      start = 1'b1;
      @(posedge clk);
      #1;
      observe(32'(busy));
      start = 1'b0;
      rst   = 1'b0;
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   task automatic test_saturation;
      string nm;
      logic [31:0] ev, ov;
      logic b;
      g = 9'h133;
      expect_v("t7_sat_bits", 15);  expect_v("t7_sat_done", 0);
      expect_v("t7_sat_locked", 1); expect_v("t7_sat_errs", 0);
      expect_v("t7_wide_bits", 40);
      pulse_start(32'd0);
      run_to_lock(100);
      for (int i = 0; i < 40; i++) begin
         gen_bit(b);
         send(1'b1, b);
      end
      observe(32'(s_bit_count)); observe(32'(s_done)); observe(32'(s_locked));
      observe(32'(s_err_count)); observe(bit_count);
      while (exp_q.size() > 0) begin
         nm = name_q.pop_front(); ev = exp_q.pop_front(); ov = obs_q.pop_front();
         n_total++;
         if (ov !== ev) begin n_bad++; $display("FAIL %s: got %0d want %0d", nm, ov, ev); end
      end
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      win_len4 = 4'd0;
      vbits    = 0;
      cycles   = 0;
      lock_bit = -1;
      lock_cyc = -1;
      dropped  = 1'b0;
      test_reset();
      test_clean_window();
      test_single_error();
      test_inverted();
      test_loss_of_lock();
      test_sparse_valid();
      test_restart_and_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
